// File: rtl/fft_in_commutator.sv
// Input commutator for the first FFT butterfly stage: a ping-pong frame store
// that turns a serial complex sample stream into four parallel quarter-frame lanes.
module fft_in_commutator #(
  parameter int unsigned NBITS = 10,
  parameter int unsigned N     = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*NBITS-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [2*NBITS-1:0] fftIn0_up,
  output logic [2*NBITS-1:0] fftIn0_down,
  output logic [2*NBITS-1:0] fftIn1_up,
  output logic [2*NBITS-1:0] fftIn1_down,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               frame_start,
  output logic               frame_last
);

  localparam int unsigned DW = 2 * NBITS;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned RW = AW - 1;  // read counter spans 0..N/4
  localparam int unsigned BW = AW - 2;  // beat index 0..N/4-1

  typedef enum logic {
    S_IDLE,
    S_READ
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [DW-1:0] r_mem [2*N];
  logic [AW-1:0] r_wcnt;
  logic          r_wbank;
  logic          r_rbank;
  logic [1:0]    r_full;
  logic          r_din_ready;
  logic [RW-1:0] r_rcnt;
  logic          r_dv;
  logic          r_fs;
  logic          r_fl;
  logic [DW-1:0] r_l0u;
  logic [DW-1:0] r_l0d;
  logic [DW-1:0] r_l1u;
  logic [DW-1:0] r_l1d;

  logic          w_wr;
  logic          w_wrap;
  logic          w_adv;
  logic          w_done;
  logic          w_wbank_nxt;
  logic [1:0]    w_full_nxt;
  logic          w_load;
  logic          w_dv_nxt;
  logic          w_rbank_nxt;
  logic [RW-1:0] w_rcnt_nxt;
  logic          w_rd_bank;
  logic [BW-1:0] w_rd_beat;
  logic [DW-1:0] w_rd_l0u;
  logic [DW-1:0] w_rd_l0d;
  logic [DW-1:0] w_rd_l1u;
  logic [DW-1:0] w_rd_l1d;

  assign w_wr        = din_valid & r_din_ready;
  assign w_wrap      = w_wr & (r_wcnt == AW'(N - 1));
  assign w_wbank_nxt = r_wbank ^ w_wrap;
  assign w_adv       = ~r_dv | dout_ready;
  assign w_done      = r_dv & dout_ready & r_fl;

  // A write-side set and a read-side clear always target different banks
  always_comb begin
    w_full_nxt = r_full;
    if (w_wrap) w_full_nxt[r_wbank] = 1'b1;
    if (w_done) w_full_nxt[r_rbank] = 1'b0;
  end

  // Quarter offsets are the top two index bits: 00, 10, 01, 11 -> k, k+N/2, k+N/4, k+3N/4
  assign w_rd_l0u = r_mem[{w_rd_bank, 2'b00, w_rd_beat}];
  assign w_rd_l0d = r_mem[{w_rd_bank, 2'b10, w_rd_beat}];
  assign w_rd_l1u = r_mem[{w_rd_bank, 2'b01, w_rd_beat}];
  assign w_rd_l1d = r_mem[{w_rd_bank, 2'b11, w_rd_beat}];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rbank_nxt = r_rbank;
    w_load      = 1'b0;
    w_dv_nxt    = r_dv;
    w_rd_bank   = r_rbank;
    w_rd_beat   = r_rcnt[BW-1:0];
    case (r_state)
      S_IDLE: begin
        if (r_full[r_rbank]) begin
          w_state_nxt = S_READ;
          w_rcnt_nxt  = '0;
        end
      end
      S_READ: begin
        if (w_done) begin
          w_rbank_nxt = ~r_rbank;
          // Next frame already buffered: issue its beat 0 on the same edge
          if (r_full[~r_rbank]) begin
            w_load     = 1'b1;
            w_rd_bank  = ~r_rbank;
            w_rd_beat  = '0;
            w_rcnt_nxt = RW'(1);
            w_dv_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_rcnt_nxt  = '0;
            w_dv_nxt    = 1'b0;
          end
        end else if (w_adv) begin
          if (!r_rcnt[RW-1]) begin
            w_load     = 1'b1;
            w_rcnt_nxt = r_rcnt + RW'(1);
            w_dv_nxt   = 1'b1;
          end else begin
            w_dv_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[{r_wbank, r_wcnt}] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt      <= '0;
      r_wbank     <= 1'b0;
      r_rbank     <= 1'b0;
      r_full      <= '0;
      r_din_ready <= 1'b0;
      r_rcnt      <= '0;
      r_dv        <= 1'b0;
      r_fs        <= 1'b0;
      r_fl        <= 1'b0;
      r_l0u       <= '0;
      r_l0d       <= '0;
      r_l1u       <= '0;
      r_l1d       <= '0;
    end else begin
      if (w_wr) r_wcnt <= r_wcnt + AW'(1);
      r_wbank     <= w_wbank_nxt;
      r_full      <= w_full_nxt;
      r_din_ready <= ~w_full_nxt[w_wbank_nxt];
      r_rbank     <= w_rbank_nxt;
      r_rcnt      <= w_rcnt_nxt;
      r_dv        <= w_dv_nxt;
      if (w_load) begin
        r_l0u <= w_rd_l0u;
        r_l0d <= w_rd_l0d;
        r_l1u <= w_rd_l1u;
        r_l1d <= w_rd_l1d;
        r_fs  <= (w_rd_beat == '0);
        r_fl  <= (w_rd_beat == '1);
      end else if (!w_dv_nxt) begin
        r_fs <= 1'b0;
        r_fl <= 1'b0;
      end
    end
  end

  assign din_ready   = r_din_ready;
  assign dout_valid  = r_dv;
  assign frame_start = r_fs;
  assign frame_last  = r_fl;
  assign fftIn0_up   = r_l0u;
  assign fftIn0_down = r_l0d;
  assign fftIn1_up   = r_l1u;
  assign fftIn1_down = r_l1d;

endmodule

// File: tb/tb_fft_in_commutator.sv
// Bench for fft_in_commutator: frame-level reorder model plus directed scenarios.
module tb_fft_in_commutator;

  localparam int unsigned NBITS = 10;
  localparam int unsigned N     = 128;
  localparam int unsigned DW    = 2 * NBITS;
  localparam int unsigned Q     = N / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] fftIn0_up;
  logic [DW-1:0] fftIn0_down;
  logic [DW-1:0] fftIn1_up;
  logic [DW-1:0] fftIn1_down;
  logic          dout_valid;
  logic          dout_ready;
  logic          frame_start;
  logic          frame_last;

  fft_in_commutator #(.NBITS(NBITS), .N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .fftIn0_up(fftIn0_up), .fftIn0_down(fftIn0_down),
    .fftIn1_up(fftIn1_up), .fftIn1_down(fftIn1_down),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_start(frame_start), .frame_last(frame_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] l0u;
    logic [DW-1:0] l0d;
    logic [DW-1:0] l1u;
    logic [DW-1:0] l1d;
    logic          fs;
    logic          fl;
  } beat_t;

  beat_t         beatq[$];
  beat_t         nb;
  logic [DW-1:0] samp[$];
  int            pending    = 0;
  int            beats_seen = 0;
  int            total      = 0;
  int            bad        = 0;
  int            post_cnt   = 0;
  int            stall_cyc  = 0;
  int            rdy_mode   = 1;  // 0 low, 1 high, 2 random
  logic          prev_stall = 1'b0;
  logic [95:0]   prev_out;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ramp(input int i);
    logic [NBITS-1:0] re;
    logic [NBITS-1:0] im;
    re = NBITS'(i);
    im = NBITS'(-i);
    return {re, im};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst)              post_cnt <= 0;
    else if (post_cnt < 3) post_cnt <= post_cnt + 1;
  end

  // Downstream ready driver
  initial begin
    dout_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_ready = (rdy_mode == 2) ? 1'(($urandom_range(0, 1))) : (rdy_mode == 1);
    end
  end

  // Reference model and per-cycle compare, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        samp.delete();
        beatq.delete();
        pending    = 0;
        prev_stall = 1'b0;
      end else begin
        if (post_cnt > 0) chk("din_ready", 96'(din_ready), 96'(pending < 2));
        chk("spurious_valid", 96'(dout_valid && beatq.size() == 0), 96'(0));
        if (dout_valid && beatq.size() > 0) begin
          chk("lanes", 96'({fftIn0_up, fftIn0_down, fftIn1_up, fftIn1_down}),
              96'({beatq[0].l0u, beatq[0].l0d, beatq[0].l1u, beatq[0].l1d}));
          chk("flags", 96'({frame_start, frame_last}), 96'({beatq[0].fs, beatq[0].fl}));
        end
        if (prev_stall)
          chk("stall_hold", 96'({dout_valid, frame_start, frame_last, fftIn0_up, fftIn0_down,
                                 fftIn1_up, fftIn1_down}), prev_out);
        prev_stall = dout_valid && !dout_ready;
        prev_out   = 96'({1'b1, frame_start, frame_last, fftIn0_up, fftIn0_down,
                          fftIn1_up, fftIn1_down});
        if (dout_valid && dout_ready && beatq.size() > 0) begin
          if (beatq[0].fl) pending--;
          void'(beatq.pop_front());
          beats_seen++;
        end
        if (din_valid && din_ready) begin
          samp.push_back(din);
          if (samp.size() == N) begin
            for (int k = 0; k < int'(Q); k++) begin
              nb.l0u = samp[k];
              nb.l0d = samp[k + N/2];
              nb.l1u = samp[k + N/4];
              nb.l1d = samp[k + 3*N/4];
              nb.fs  = (k == 0);
              nb.fl  = (k == int'(Q) - 1);
              beatq.push_back(nb);
            end
            samp.delete();
            pending++;
          end
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d);
    int t;
    t = 0;
    din       = d;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    stall_cyc += t;
    if (t >= 2000) chk("send_timeout", 96'(t), 96'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    din_valid = 1'b0;
    while ((beatq.size() != 0 || dout_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drained"}, 96'(beatq.size()), 96'(0));
    @(posedge clk);
    #1;
  endtask

  // Latency and literal beat checks for a ramp frame whose last sample was just accepted
  task automatic frame_pins(input string nm);
    int t;
    din_valid = 1'b0;
    @(negedge clk); chk({nm, "_lat1"}, 96'(dout_valid), 96'(0));
    @(negedge clk); chk({nm, "_lat2"}, 96'(dout_valid), 96'(0));
    @(negedge clk); chk({nm, "_lat3"}, 96'(dout_valid), 96'(1));
    chk({nm, "_beat0_re"}, 96'({fftIn0_up[DW-1:NBITS], fftIn0_down[DW-1:NBITS],
                               fftIn1_up[DW-1:NBITS], fftIn1_down[DW-1:NBITS]}),
        96'({10'd0, 10'd64, 10'd32, 10'd96}));
    chk({nm, "_beat0_im"}, 96'(fftIn0_down[NBITS-1:0]), 96'(10'h3C0));
    chk({nm, "_beat0_flags"}, 96'({frame_start, frame_last}), 96'(2'b10));
    t = 0;
    while (!(dout_valid && frame_last) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_beat31_re"}, 96'({fftIn0_up[DW-1:NBITS], fftIn0_down[DW-1:NBITS],
                                fftIn1_up[DW-1:NBITS], fftIn1_down[DW-1:NBITS]}),
        96'({10'd31, 10'd95, 10'd63, 10'd127}));
    chk({nm, "_beat31_im"}, 96'(fftIn1_down[NBITS-1:0]), 96'(10'h381));
    chk({nm, "_beat31_flags"}, 96'({frame_start, frame_last}), 96'(2'b01));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_async", 96'({din_ready, dout_valid, frame_start, frame_last}), 96'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    rst       = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 96'({din_ready, dout_valid, frame_start, frame_last, fftIn0_up,
                            fftIn0_down, fftIn1_up, fftIn1_down}), 96'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk); chk("ready_no_edge_yet", 96'(din_ready), 96'(0));
    @(negedge clk); chk("ready_first_edge", 96'(din_ready), 96'(1));
    @(posedge clk);
    #1;

    // Gapless ramp frame
    for (int i = 0; i < int'(N); i++) send(ramp(i));
    frame_pins("ramp");
    drain("ramp");

    // Same ramp with input gaps: output must be identical
    for (int i = 0; i < int'(N); i++) begin
      if (i % 17 == 5) begin
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      send(ramp(i));
    end
    frame_pins("gaps");
    drain("gaps");

    // Three continuous frames, no backpressure
    stall_cyc = 0;
    base      = beats_seen;
    for (int i = 0; i < int'(3*N); i++) send(DW'($urandom));
    drain("cont");
    chk("cont_beats", 96'(beats_seen - base), 96'(96));
    chk("cont_no_stall", 96'(stall_cyc), 96'(0));

    // Consumer stalled: both banks fill, 257th waits for frame 0 to finish
    rdy_mode = 0;
    @(posedge clk);
    #1;
    base = beats_seen;
    for (int i = 0; i < int'(2*N); i++) send(DW'($urandom));
    din_valid = 1'b0;
    @(negedge clk); chk("full_ready_low", 96'(din_ready), 96'(0));
    @(posedge clk);
    #1;
    fork
      send(DW'($urandom));
      begin
        repeat (20) @(posedge clk);
        #1;
        rdy_mode = 1;
      end
    join
    chk("s257_after_beat31", 96'((beats_seen - base) >= 32), 96'(1));
    for (int i = 0; i < int'(N) - 1; i++) send(DW'($urandom));
    drain("stall");
    chk("stall_beats", 96'(beats_seen - base), 96'(96));

    // Random consumer backpressure with random input gaps
    rdy_mode = 2;
    base     = beats_seen;
    for (int i = 0; i < int'(2*N); i++) begin
      if ($urandom_range(0, 3) == 0) begin
        din_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send(DW'($urandom));
    end
    drain("rand");
    chk("rand_beats", 96'(beats_seen - base), 96'(64));
    rdy_mode = 1;
    @(posedge clk);
    #1;

    // Reset mid-frame, then a fresh frame must start at index 0
    for (int i = 0; i < 70; i++) send(DW'($urandom));
    din_valid = 1'b0;
    do_reset();
    for (int i = 0; i < int'(N); i++) send(ramp(i));
    frame_pins("post_rst_a");
    drain("post_rst_a");

    // Reset mid-read at beat 10
    base = beats_seen;
    for (int i = 0; i < int'(N); i++) send(DW'($urandom));
    din_valid = 1'b0;
    begin
      int t;
      t = 0;
      while ((beats_seen - base) < 10 && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("mid_read_reach", 96'(beats_seen - base), 96'(10));
    end
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < int'(N); i++) send(ramp(i));
    frame_pins("post_rst_b");
    drain("post_rst_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fft_in_commutator.md
FFT_IN_COMMUTATOR -- requirements
Module: fft_in_commutator

Interface
REQ-001 The module SHALL have parameter NBITS, default 10, giving the bits per real or imaginary component.
REQ-002 The module SHALL have parameter N, default 128, giving the FFT frame length; it is a power of two and at least 8.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port din, input, 2*NBITS bits: one complex sample; bits [2*NBITS-1:NBITS] are real and [NBITS-1:0] are imaginary, both two's complement.
REQ-006 The module SHALL have port din_valid, input, 1 bit: din carries a sample.
REQ-007 The module SHALL have port din_ready, output, 1 bit: the module can accept din this cycle.
REQ-008 The module SHALL have ports fftIn0_up, fftIn0_down, fftIn1_up and fftIn1_down, each an output of 2*NBITS bits: the four parallel lanes feeding the first butterfly stage, in the same format as din.
REQ-009 The module SHALL have port dout_valid, output, 1 bit: the lanes carry a beat.
REQ-010 The module SHALL have port dout_ready, input, 1 bit: the downstream consumer takes the beat.
REQ-011 The module SHALL have port frame_start, output, 1 bit: high with beat 0 of each frame.
REQ-012 The module SHALL have port frame_last, output, 1 bit: high with beat N/4-1 of each frame.

Function
REQ-013 The module SHALL hold a ping-pong store of two banks, each N words of 2*NBITS bits.
REQ-014 A sample SHALL be accepted on a rising edge where din_valid and din_ready are both high; it is written to the current write bank at index wcnt, and wcnt then increments.
REQ-015 When wcnt wraps from N-1 to 0, the module SHALL set the write bank's full flag and toggle the write bank on the same edge.
REQ-016 din_ready SHALL equal NOT(full flag of the current write bank); this is low only when both banks are full.
REQ-017 The read side SHALL be a two-state FSM: IDLE and READ.
REQ-018 The FSM SHALL go IDLE->READ when the read bank's full flag is set, and stay in READ for N/4 beats.
REQ-019 On beat k (0..N/4-1), the lanes SHALL carry fftIn0_up = x[k], fftIn0_down = x[k+N/2], fftIn1_up = x[k+N/4] and fftIn1_down = x[k+3N/4].
REQ-020 A beat SHALL complete on an edge where dout_valid and dout_ready are both high.
REQ-021 While dout_valid is high and dout_ready is low, all lanes, frame_start and frame_last SHALL hold stable.
REQ-022 After beat N/4-1 completes, the module SHALL clear the read bank's full flag and toggle the read bank; the FSM SHALL re-enter READ without a bubble if the other bank is already full, otherwise go to IDLE.
REQ-023 Outputs SHALL be registered; with the FSM IDLE, dout_valid SHALL rise on the second rising edge after the edge that accepted the frame's last sample.
REQ-024 A write and a read-side flag clear on the same edge SHALL both take effect; din_ready SHALL reflect the updated flags on the next cycle.
REQ-025 din samples presented while din_ready is low SHALL be ignored, with no write and no counter change.
REQ-026 The module SHALL perform no arithmetic and no width change; samples pass through bit-exact.
REQ-027 Implementation SHALL fit in 120-400 lines of RTL.

Reset
REQ-028 While rst=0, the module SHALL force din_ready=0, dout_valid=0, frame_start=0, frame_last=0, all lanes=0, wcnt=0, both full flags=0, write bank=0, read bank=0 and FSM=IDLE.
REQ-029 Memory contents are not reset; a partial frame or an unread frame present at reset SHALL be discarded.
REQ-030 din_ready SHALL rise on the first rising edge after rst deasserts.

Verification
REQ-031 With N=128 and NBITS=10, a ramp x[i] = {real i, imag -i} and dout_ready held high SHALL produce beat 0 lanes of 0, 64, 32, 96 and beat 31 lanes of 31, 95, 63, 127; frame_start SHALL be high on beat 0 only and frame_last on beat 31 only.
REQ-032 Continuous din_valid for three frames with dout_ready high SHALL keep din_ready high throughout and produce 96 contiguous beats.
REQ-033 With dout_ready held low after the first frame, din_ready SHALL drop on the edge that accepts the 256th sample, and the 257th sample SHALL be accepted only after beat 31 of frame 0 completes.
REQ-034 Toggling dout_ready randomly SHALL leave lanes stable while stalled, and beat order and values SHALL still match REQ-019.
REQ-035 Asserting rst=0 mid-frame at sample 70 and mid-read at beat 10 SHALL drop dout_valid immediately, and the first frame after reset SHALL start from a fresh wcnt=0.
REQ-036 Setting din_valid=0 for gaps inside a frame SHALL leave the output identical to the gapless case, and dout_valid SHALL rise 2 edges after the final accepted sample.
